// File: rtl/logic16_bist_if.sv
// Bus between the logic16_bist sequencer (master) and its environment (slave):
// the run control/result signals plus the operand/result lines of the AND unit under test.
interface logic16_bist_if;
   // start is a level request, honoured only while the sequencer is idle or done;
   // done then holds, with the results stable, until the next run is launched.
   logic        start;
   logic        busy;
   logic        done;
   logic        pass;
   logic [7:0]  err_count;
   logic [8:0]  first_fail_idx;
   logic [15:0] first_fail_out;
   logic [15:0] dut_a;
   logic [15:0] dut_b;
   logic [15:0] dut_out;
   logic [1:0]  dbg_state;

   modport master (
      input  start, dut_out,
      output busy, done, pass, err_count, first_fail_idx, first_fail_out,
             dut_a, dut_b, dbg_state
   );

   modport slave (
      output start, dut_out,
      input  busy, done, pass, err_count, first_fail_idx, first_fail_out,
             dut_a, dut_b, dbg_state
   );
endinterface

// File: rtl/logic16_bist.sv
// On-chip self-test sequencer for a 16-bit AND unit: 6 directed vectors, then N_RAND
// LFSR vectors, each held SETTLE cycles and checked against a&b in one sample cycle.
module logic16_bist #(
   parameter int unsigned N_RAND = 10,
   parameter int unsigned SETTLE = 1,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic           clk,
   input  logic           rst_n,
   logic16_bist_if.master bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;

   localparam logic [8:0] LAST_IDX = 9'(N_RAND + 5);
   localparam int         CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t        state;
   logic          launch_q;
   logic [8:0]    idx;
   logic [CW-1:0] cnt;
   logic [15:0]   lfsr;

   logic          mismatch;
   logic [7:0]    err_next;
   logic [8:0]    idx_next;
   logic [15:0]   lfsr_adv;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Returns {a, b} for vector i; l is the LFSR value that vector uses if it is random.
   function automatic logic [31:0] vec(input logic [8:0] i, input logic [15:0] l);
      case (i)
         9'd0:    return {16'h0000, 16'h0000};
         9'd1:    return {16'h0000, 16'hFFFF};
         9'd2:    return {16'hFFFF, 16'hFFFF};
         9'd3:    return {16'hAAAA, 16'h5555};
         9'd4:    return {16'h3CC3, 16'h0FF0};
         9'd5:    return {16'h1234, 16'h9876};
         default: return {l, {l[7:0], l[15:8]} ^ 16'h5A5A};
      endcase
   endfunction

   always_comb begin
      // Written so that an X/Z result falls through as a mismatch.
      mismatch = 1'b1;
      if (bus.dut_out == (bus.dut_a & bus.dut_b)) mismatch = 1'b0;
      err_next = bus.err_count;
      if (mismatch && (bus.err_count != 8'hFF)) err_next = bus.err_count + 8'd1;
      idx_next = idx + 9'd1;
      lfsr_adv = (idx >= 9'd6) ? lfsr_step(lfsr) : lfsr;
   end

   assign bus.dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         launch_q           <= 1'b0;
         idx                <= '0;
         cnt                <= '0;
         lfsr               <= '0;
         bus.busy           <= 1'b0;
         bus.done           <= 1'b0;
         bus.pass           <= 1'b0;
         bus.err_count      <= '0;
         bus.first_fail_idx <= '0;
         bus.first_fail_out <= '0;
         bus.dut_a          <= '0;
         bus.dut_b          <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // The request is registered first; the run launches on the following edge.
               if (launch_q) begin
                  state              <= DRIVE;
                  launch_q           <= 1'b0;
                  idx                <= '0;
                  cnt                <= '0;
                  lfsr               <= SEED;
                  {bus.dut_a, bus.dut_b} <= vec(9'd0, SEED);
                  bus.busy           <= 1'b1;
                  bus.done           <= 1'b0;
                  bus.pass           <= 1'b0;
                  bus.err_count      <= '0;
                  bus.first_fail_idx <= '0;
                  bus.first_fail_out <= '0;
               end else if (bus.start) begin
                  launch_q <= 1'b1;
               end
            end
            DRIVE: begin
               if (cnt == CW'(SETTLE - 1)) begin
                  state <= SAMPLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SAMPLE: begin
               bus.err_count <= err_next;
               if (mismatch && (bus.err_count == 8'd0)) begin
                  bus.first_fail_idx <= idx;
                  bus.first_fail_out <= bus.dut_out;
               end
               lfsr <= lfsr_adv;
               if (idx == LAST_IDX) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bus.pass <= (err_next == 8'd0);
               end else begin
                  state <= DRIVE;
                  idx   <= idx_next;
                  {bus.dut_a, bus.dut_b} <= vec(idx_next, lfsr_adv);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_logic16_bist.sv
// Bench for logic16_bist: two instances (short and long runs) beside a configurable faulty AND unit.
module tb_logic16_bist;
   localparam int W = 33;  // {err_count, first_fail_idx, first_fail_out}
   localparam int N0 = 0;
   localparam int S0 = 1;
   localparam int N1 = 300;
   localparam int S1 = 2;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int LIMIT = 4000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   mode0 = 0;
   int   mode1 = 0;
   logic [15:0] fkey = 16'h0;
   logic [15:0] fmask = 16'h1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [W-1:0] exp_q[$];

   logic [15:0] dir_a [6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
   logic [15:0] dir_b [6] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h5555, 16'h0FF0, 16'h9876};

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   logic16_bist_if if0 ();
   logic16_bist_if if1 ();

   logic16_bist #(.N_RAND(N0), .SETTLE(S0), .SEED(SEED)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   logic16_bist #(.N_RAND(N1), .SETTLE(S1), .SEED(SEED)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   // Unit under test: 0 good, 1 out[0] stuck 0, 2 OR, 3 NAND, 4 keyed random corruption.
   function automatic logic [15:0] fault_out(input int mode, input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] key, input logic [15:0] mask);
      case (mode)
         1:       return (a & b) & 16'hFFFE;
         2:       return a | b;
         3:       return ~(a & b);
         4:       return (a & b) ^ ((((a ^ b) & 16'h000F) == key) ? mask : 16'h0000);
         default: return a & b;
      endcase
   endfunction

   assign if0.dut_out = fault_out(mode0, if0.dut_a, if0.dut_b, fkey, fmask);
   assign if1.dut_out = fault_out(mode1, if1.dut_a, if1.dut_b, fkey, fmask);

   // ---------------- reference model ----------------
   task automatic model_run(input int n_rand, input int mode);
      logic [15:0] l, a, b, got, fout;
      int err, fidx;
      l = SEED; err = 0; fidx = 0; fout = 16'h0;
      for (int i = 0; i < 6 + n_rand; i++) begin
         if (i < 6) begin
            a = dir_a[i];
            b = dir_b[i];
         end else begin
            a = l;
            b = ((l << 8) | (l >> 8)) ^ 16'h5A5A;
            l = (l << 1) | (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 16'h0001);
         end
         got = fault_out(mode, a, b, fkey, fmask);
         if (got !== (a & b)) begin
            if (err == 0) begin
               fidx = i;
               fout = got;
            end
            err++;
         end
      end
      if (err > 255) err = 255;
      exp_q.push_back({8'(err), 9'(fidx), fout});
   endtask

   function automatic int run_edges(input int n_rand, input int settle);
      return (6 + n_rand) * (settle + 1) + 1;
   endfunction

   // ---------------- observation / drivers ----------------
   function automatic logic [W-1:0] rd_res(input int sel);
      if (sel == 0) return {if0.err_count, if0.first_fail_idx, if0.first_fail_out};
      return {if1.err_count, if1.first_fail_idx, if1.first_fail_out};
   endfunction

   // {busy, done, pass, state}
   function automatic logic [4:0] rd_flags(input int sel);
      if (sel == 0) return {if0.busy, if0.done, if0.pass, if0.dbg_state};
      return {if1.busy, if1.done, if1.pass, if1.dbg_state};
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) if0.start = v;
      else if1.start = v;
   endtask

   // Raises start before an edge (the accepting edge), then counts edges until done is seen.
   task automatic launch(input int sel, input bit hold, output int edges);
      @(negedge clk);
      set_start(sel, 1'b1);
      @(posedge clk); #1;
      if (!hold) set_start(sel, 1'b0);
      edges = 0;
      do begin
         @(posedge clk); #1;
         edges++;
      end while ((rd_flags(sel)[3] !== 1'b1) && (edges < LIMIT));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
         n_cmp++;
         if (rd_res(s) !== '0 || rd_flags(s) !== 5'b0) begin
            n_err++;
            $display("FAIL reset_state[%0d]: got res=%h flags=%b want 0", s, rd_res(s), rd_flags(s));
         end
      end
      n_cmp++;
      if ({if0.dut_a, if0.dut_b, if1.dut_a, if1.dut_b} !== 64'h0) begin
         n_err++;
         $display("FAIL reset_operands: got %h %h want 0", if0.dut_a, if0.dut_b);
      end
   endtask

   task automatic test_scenario(input string name, input int sel, input int mode);
      int edges, want;
      logic [W-1:0] exp, got;
      logic [4:0] fl;
      if (sel == 0) mode0 = mode; else mode1 = mode;
      model_run(sel == 0 ? N0 : N1, mode);
      want = (sel == 0) ? run_edges(N0, S0) : run_edges(N1, S1);
      launch(sel, 1'b0, edges);
      exp = exp_q.pop_front();
      got = rd_res(sel);
      fl  = rd_flags(sel);
      n_cmp++;
      if (edges !== want) begin
         n_err++;
         $display("FAIL %s_done_edge: got %0d want %0d", name, edges, want);
      end
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s_result: got err=%0d idx=%0d out=%h want err=%0d idx=%0d out=%h",
                  name, got[32:25], got[24:16], got[15:0], exp[32:25], exp[24:16], exp[15:0]);
      end
      n_cmp++;
      if (fl !== {1'b0, 1'b1, (exp[32:25] == 8'd0), 2'd3}) begin
         n_err++;
         $display("FAIL %s_flags: got busy,done,pass,state=%b want pass=%b in DONE", name, fl, exp[32:25] == 8'd0);
      end
   endtask

   task automatic test_golden();
      test_scenario("golden", 0, 0);
      n_cmp++;
      if (rd_res(0) !== 33'h0 || if0.pass !== 1'b1) begin
         n_err++;
         $display("FAIL golden_const: got res=%h pass=%b want 0/1", rd_res(0), if0.pass);
      end
   endtask

   task automatic test_stuck_bit0();
      test_scenario("stuck0", 0, 1);
      n_cmp++;
      if (rd_res(0) !== {8'd1, 9'd2, 16'hFFFE}) begin
         n_err++;
         $display("FAIL stuck0_const: got %h want err=1 idx=2 out=FFFE", rd_res(0));
      end
   endtask

   task automatic test_or_unit();
      test_scenario("or_unit", 0, 2);
      n_cmp++;
      if (rd_res(0) !== {8'd4, 9'd1, 16'hFFFF}) begin
         n_err++;
         $display("FAIL or_unit_const: got %h want err=4 idx=1 out=FFFF", rd_res(0));
      end
   endtask

   task automatic test_saturate();
      test_scenario("saturate", 1, 3);
      n_cmp++;
      if (rd_res(1) !== {8'd255, 9'd0, 16'hFFFF} || if1.pass !== 1'b0) begin
         n_err++;
         $display("FAIL saturate_const: got %h pass=%b want err=255 idx=0 out=FFFF pass=0", rd_res(1), if1.pass);
      end
   endtask

   task automatic test_hold_start();
      int edges, n;
      logic [W-1:0] exp;
      mode0 = 2;
      model_run(N0, 2);
      launch(0, 1'b1, edges);
      exp = exp_q.pop_front();
      n_cmp++;
      if (edges !== run_edges(N0, S0) || rd_res(0) !== exp) begin
         n_err++;
         $display("FAIL hold_first_run: got edges=%0d res=%h want edges=%0d res=%h",
                  edges, rd_res(0), run_edges(N0, S0), exp);
      end
      // start still high while DONE: expect a relaunch with cleared results.
      mode0 = 0;
      model_run(N0, 0);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (if0.busy !== 1'b1 && n < 8);
      n_cmp++;
      if (if0.busy !== 1'b1 || if0.done !== 1'b0 || rd_res(0) !== 33'h0 || n !== 2) begin
         n_err++;
         $display("FAIL hold_relaunch: got busy=%b done=%b res=%h after %0d edges want 1/0/0 after 2",
                  if0.busy, if0.done, rd_res(0), n);
      end
      @(negedge clk);
      if0.start = 1'b0;
      n = 0;
      while (if0.done !== 1'b1 && n < LIMIT) begin
         @(posedge clk); #1;
         n++;
      end
      exp = exp_q.pop_front();
      n_cmp++;
      if (if0.done !== 1'b1 || rd_res(0) !== exp || if0.pass !== 1'b1) begin
         n_err++;
         $display("FAIL hold_second_run: got done=%b res=%h pass=%b want 1/%h/1", if0.done, rd_res(0), if0.pass, exp);
      end
   endtask

   task automatic test_reset_mid();
      mode0 = 0;
      @(negedge clk);
      if0.start = 1'b1;
      @(posedge clk); #1;
      if0.start = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
      n_cmp++;
      if (if0.dbg_state !== 2'd1 || if0.dut_a !== 16'hAAAA || if0.dut_b !== 16'h5555) begin
         n_err++;
         $display("FAIL midrun_position: got state=%0d a=%h b=%h want DRIVE AAAA 5555",
                  if0.dbg_state, if0.dut_a, if0.dut_b);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rd_res(0) !== '0 || rd_flags(0) !== 5'b0 || {if0.dut_a, if0.dut_b} !== 32'h0) begin
         n_err++;
         $display("FAIL midrun_reset: got res=%h flags=%b a=%h b=%h want all 0",
                  rd_res(0), rd_flags(0), if0.dut_a, if0.dut_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_scenario("after_reset", 0, 0);
   endtask

   task automatic test_back_to_back();
      int edges;
      logic [W-1:0] exp;
      mode0 = 1;
      model_run(N0, 1);
      launch(0, 1'b0, edges);
      exp = exp_q.pop_front();
      // Relaunch straight out of DONE; check the first cycles of the new run.
      mode0 = 2;
      model_run(N0, 2);
      @(negedge clk);
      if0.start = 1'b1;
      @(posedge clk); #1;
      if0.start = 1'b0;
      n_cmp++;
      if (if0.done !== 1'b1 || rd_res(0) !== exp) begin
         n_err++;
         $display("FAIL b2b_accept_edge: got done=%b res=%h want 1/%h", if0.done, rd_res(0), exp);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (if0.busy !== 1'b1 || if0.done !== 1'b0 || if0.dbg_state !== 2'd1) begin
         n_err++;
         $display("FAIL b2b_launch: got busy=%b done=%b state=%0d want 1/0/1", if0.busy, if0.done, if0.dbg_state);
      end
      edges = 1;
      while (if0.done !== 1'b1 && edges < LIMIT) begin
         @(posedge clk); #1;
         edges++;
      end
      exp = exp_q.pop_front();
      n_cmp++;
      if (edges !== run_edges(N0, S0) || rd_res(0) !== exp) begin
         n_err++;
         $display("FAIL b2b_second: got edges=%0d res=%h want %0d/%h", edges, rd_res(0), run_edges(N0, S0), exp);
      end
   endtask

   task automatic test_random();
      int sel, mode;
      for (int it = 0; it < 6; it++) begin
         sel   = $urandom_range(0, 1);
         mode  = $urandom_range(0, 4);
         fkey  = 16'($urandom_range(0, 15));
         fmask = 16'($urandom_range(1, 65535));
         repeat ($urandom_range(0, 5)) @(posedge clk);
         test_scenario("random", sel, mode);
      end
   endtask

   initial begin
      if0.start = 1'b0;
      if1.start = 1'b0;
      rst_n = 1'b0;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_golden();
      test_stuck_bit0();
      test_or_unit();
      test_saturate();
      test_hold_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
